addr_route_demux: RTL and testbench

Ordered request demultiplexer that sits directly downstream of the address decoder. It takes one upstream request stream plus the decoder's index and error flag, and steers each request to one of `NoPorts` downstream ports. Responses are merged back in issue order by locking onto one target while transactions are outstanding. Decode errors are absorbed by an internal error responder, so no downstream port ever sees an unmapped request.

---
 rtl/addr_route_pkg.sv | 17 +
 rtl/addr_route_err_slv.sv | 35 +++
 rtl/addr_route_demux.sv | 171 +++++++++++++++++
 tb/tb_addr_route_demux.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_route_pkg.sv
// Shared definitions for the ordered request demultiplexer.
//   idx_width() : index width for a given port count (at least 1 bit)
//   state_e     : IDLE (nothing outstanding) / LOCKED (outstanding to tgt_q)
// Target encoding used by the demux: {err, idx}, IdxWidth+1 bits. The MSB
// set marks the internal error responder (ERR_TGT = {1'b1, '0}).
package addr_route_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/addr_route_err_slv.sv
// Error responder for decode errors: counts accepted-but-unanswered error
// requests and flags a pending response one cycle after acceptance.
//   clk_i, rst_i : clock, synchronous active-high reset
//   inc_i        : error request accepted
//   dec_i        : error response handshaken
//   pend_o       : at least one error response pending
module addr_route_err_slv
  import addr_route_pkg::*;
#(
  parameter int unsigned CntWidth = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic pend_o
);

  logic [CntWidth-1:0] err_pend_q, err_pend_d;

  always_comb begin
    err_pend_d = err_pend_q + CntWidth'(inc_i) - CntWidth'(dec_i);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_pend_q <= '0;
    end else begin
      err_pend_q <= err_pend_d;
    end
  end

  assign pend_o = (err_pend_q != '0);

endmodule

// File: rtl/addr_route_demux.sv
// Ordered request demultiplexer behind the address decoder. Steers each
// request to one downstream port (or the internal error responder) and
// merges responses in issue order by locking onto one target while any
// transaction is outstanding.
// Ports:
//   clk_i, rst_i                      : clock, synchronous active-high reset
//   req_valid_i/req_ready_o           : upstream request handshake
//   req_idx_i, req_dec_error_i        : decoded target / decode error
//   req_payload_i                     : request payload
//   mst_valid_o/mst_ready_i           : per-port request handshake
//   mst_payload_o                     : payload broadcast to all ports
//   rsp_valid_i/rsp_ready_o/rsp_data_i: per-port response channel
//   rsp_valid_o/rsp_ready_i/rsp_data_o: merged response channel
//   rsp_err_o                         : merged response is from error responder
//   busy_o                            : transactions outstanding
// Build option: ADDR_ROUTE_DEMUX_SPILL_EN inserts a two-entry spill stage on
// the upstream request (registered req_ready_o, one cycle extra latency).
module addr_route_demux
  import addr_route_pkg::*;
#(
  parameter int unsigned NoPorts      = 2,
  parameter int unsigned MaxTrans     = 4,
  parameter int unsigned PayloadWidth = 32,
  parameter int unsigned RspWidth     = 32,
  parameter int unsigned IdxWidth     = addr_route_pkg::idx_width(NoPorts),
  parameter int unsigned CntWidth     = $clog2(MaxTrans + 1)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [IdxWidth-1:0]               req_idx_i,
  input  logic                              req_dec_error_i,
  input  logic [PayloadWidth-1:0]           req_payload_i,
  output logic [NoPorts-1:0]                mst_valid_o,
  input  logic [NoPorts-1:0]                mst_ready_i,
  output logic [PayloadWidth-1:0]           mst_payload_o,
  input  logic [NoPorts-1:0]                rsp_valid_i,
  output logic [NoPorts-1:0]                rsp_ready_o,
  input  logic [NoPorts-1:0][RspWidth-1:0]  rsp_data_i,
  output logic                              rsp_valid_o,
  input  logic                              rsp_ready_i,
  output logic [RspWidth-1:0]               rsp_data_o,
  output logic                              rsp_err_o,
  output logic                              busy_o
);

  typedef logic [IdxWidth:0] tgt_t;
  localparam tgt_t ERR_TGT = {1'b1, {IdxWidth{1'b0}}};

  // Request as seen by the steering logic (after the optional spill stage).
  logic                    s_valid, s_ready, s_err;
  logic [IdxWidth-1:0]     s_idx;
  logic [PayloadWidth-1:0] s_payload;

`ifdef ADDR_ROUTE_DEMUX_SPILL_EN
  localparam int unsigned SW = 1 + IdxWidth + PayloadWidth;
  logic [SW-1:0] a_data_q, b_data_q;
  logic          a_full_q, b_full_q;
  logic          a_fill, a_drain, b_fill, b_drain;

  // Entry A takes upstream data; it spills into B only when the steering
  // side stalls, so ready can be driven purely from flop state.
  assign a_fill  = req_valid_i && req_ready_o;
  assign a_drain = a_full_q && !b_full_q;
  assign b_fill  = a_drain && !s_ready;
  assign b_drain = b_full_q && s_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_full_q <= 1'b0;
      b_full_q <= 1'b0;
      a_data_q <= '0;
      b_data_q <= '0;
    end else begin
      if (a_fill) a_data_q <= {req_dec_error_i, req_idx_i, req_payload_i};
      if (a_fill || a_drain) a_full_q <= a_fill;
      if (b_fill) b_data_q <= a_data_q;
      if (b_fill || b_drain) b_full_q <= b_fill;
    end
  end

  assign req_ready_o                 = !a_full_q || !b_full_q;
  assign s_valid                     = a_full_q || b_full_q;
  assign {s_err, s_idx, s_payload}   = b_full_q ? b_data_q : a_data_q;
`else
  assign s_valid     = req_valid_i;
  assign s_err       = req_dec_error_i;
  assign s_idx       = req_idx_i;
  assign s_payload   = req_payload_i;
  assign req_ready_o = s_ready;
`endif

  logic [CntWidth-1:0] cnt_q, cnt_d;
  tgt_t                tgt_q, tgt_d;
  tgt_t                s_tgt;
  state_e              state;
  logic                stall, acc, rsp_hs, tgt_err, idx_ok, err_pend;
  logic [IdxWidth-1:0] lock_idx;

  assign s_tgt = s_err ? ERR_TGT : {1'b0, s_idx};
  assign state = (cnt_q == '0) ? IDLE : LOCKED;
  // While locked only the same target may follow, and only below saturation.
  assign stall = (state == LOCKED) &&
                 ((s_tgt != tgt_q) || (cnt_q == CntWidth'(MaxTrans)));
  assign idx_ok = (32'(s_idx) < NoPorts);

  always_comb begin
    mst_valid_o = '0;
    s_ready     = 1'b0;
    if (!stall) begin
      if (s_err) begin
        s_ready = 1'b1;
      end else if (idx_ok) begin
        mst_valid_o[s_idx] = s_valid;
        s_ready            = mst_ready_i[s_idx];
      end
    end
  end

  assign mst_payload_o = s_payload;
  assign acc           = s_valid && s_ready;

  assign tgt_err  = tgt_q[IdxWidth];
  assign lock_idx = tgt_q[IdxWidth-1:0];

  always_comb begin
    rsp_ready_o = '0;
    rsp_valid_o = 1'b0;
    rsp_data_o  = '0;
    rsp_err_o   = 1'b0;
    if (tgt_err) begin
      rsp_valid_o = err_pend;
      rsp_err_o   = err_pend;
    end else begin
      rsp_ready_o[lock_idx] = rsp_ready_i;
      rsp_valid_o           = rsp_valid_i[lock_idx] && (cnt_q != '0);
      rsp_data_o            = rsp_data_i[lock_idx];
    end
  end

  assign rsp_hs = rsp_valid_o && rsp_ready_i;
  assign busy_o = (state == LOCKED);

  always_comb begin
    cnt_d = cnt_q + CntWidth'(acc) - CntWidth'(rsp_hs);
    tgt_d = tgt_q;
    if (acc && (state == IDLE)) tgt_d = s_tgt;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      tgt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tgt_q <= tgt_d;
    end
  end

  addr_route_err_slv #(
    .CntWidth(CntWidth)
  ) u_err_slv (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (acc && s_err),
    .dec_i (rsp_hs && tgt_err),
    .pend_o(err_pend)
  );

endmodule

// File: tb/tb_addr_route_demux.sv
module tb_addr_route_demux;

  localparam int NP = 2;
  localparam int MT = 4;
  localparam int PW = 32;
  localparam int RW = 32;

  logic                    clk_i = 1'b0;
  logic                    rst_i;
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic [0:0]              req_idx_i;
  logic                    req_dec_error_i;
  logic [PW-1:0]           req_payload_i;
  logic [NP-1:0]           mst_valid_o;
  logic [NP-1:0]           mst_ready_i;
  logic [PW-1:0]           mst_payload_o;
  logic [NP-1:0]           rsp_valid_i;
  logic [NP-1:0]           rsp_ready_o;
  logic [NP-1:0][RW-1:0]   rsp_data_i;
  logic                    rsp_valid_o;
  logic                    rsp_ready_i;
  logic [RW-1:0]           rsp_data_o;
  logic                    rsp_err_o;
  logic                    busy_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  addr_route_demux #(
    .NoPorts(NP), .MaxTrans(MT), .PayloadWidth(PW), .RspWidth(RW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_idx_i(req_idx_i), .req_dec_error_i(req_dec_error_i),
    .req_payload_i(req_payload_i),
    .mst_valid_o(mst_valid_o), .mst_ready_i(mst_ready_i),
    .mst_payload_o(mst_payload_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_data_i(rsp_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o), .busy_o(busy_o)
  );

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    req_valid_i = 0; req_idx_i = 0; req_dec_error_i = 0; req_payload_i = '0;
    mst_ready_i = 2'b11; rsp_valid_i = '0; rsp_ready_i = 0; rsp_data_i = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_i = 1;
    step(); step();
    rst_i = 0;
    @(negedge clk_i);
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready_o); end
    n_cmp++; if (mst_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_mst_valid: got %b want 00", mst_valid_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_o); end
    n_cmp++; if (rsp_err_o !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err_o); end
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_err++; $display("FAIL reset_cnt: got %0d want 0", dut.cnt_q); end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      req_valid_i = 1; req_idx_i = 1; req_payload_i = 32'hA000 + i;
      @(negedge clk_i);
      n_cmp++; if (mst_valid_o !== 2'b10) begin n_err++; $display("FAIL b2b_mst_valid[%0d]: got %b want 10", i, mst_valid_o); end
      n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_req_ready[%0d]: got %b want 1", i, req_ready_o); end
      n_cmp++; if (mst_payload_o !== 32'hA000 + i) begin n_err++; $display("FAIL b2b_payload[%0d]: got %h want %h", i, mst_payload_o, 32'hA000 + i); end
      step();
    end
    req_valid_i = 0;
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd3) begin n_err++; $display("FAIL b2b_cnt: got %0d want 3", dut.cnt_q); end
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_busy: got %b want 1", busy_o); end
    step();
    for (int i = 0; i < 3; i++) begin
      rsp_valid_i = 2'b10; rsp_ready_i = 1; rsp_data_i[1] = 32'hB000 + i;
      @(negedge clk_i);
      n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL b2b_rsp_valid[%0d]: got %b want 1", i, rsp_valid_o); end
      n_cmp++; if (rsp_ready_o !== 2'b10) begin n_err++; $display("FAIL b2b_rsp_ready[%0d]: got %b want 10", i, rsp_ready_o); end
      n_cmp++; if (rsp_data_o !== 32'hB000 + i) begin n_err++; $display("FAIL b2b_rsp_data[%0d]: got %h want %h", i, rsp_data_o, 32'hB000 + i); end
      step();
    end
    rsp_valid_i = 0; rsp_ready_i = 0;
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_err++; $display("FAIL b2b_cnt_end: got %0d want 0", dut.cnt_q); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL b2b_busy_end: got %b want 0", busy_o); end
    step();
  endtask

  task automatic test_switch();
    req_valid_i = 1; req_idx_i = 0;
    @(negedge clk_i);
    n_cmp++; if (mst_valid_o !== 2'b01) begin n_err++; $display("FAIL sw_first_valid: got %b want 01", mst_valid_o); end
    step();
    req_idx_i = 1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk_i);
      n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL sw_stall_ready[%0d]: got %b want 0", i, req_ready_o); end
      n_cmp++; if (mst_valid_o !== 2'b00) begin n_err++; $display("FAIL sw_stall_valid[%0d]: got %b want 00", i, mst_valid_o); end
      step();
    end
    rsp_valid_i = 2'b01; rsp_ready_i = 1;
    @(negedge clk_i);
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL sw_rsp_valid: got %b want 1", rsp_valid_o); end
    n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL sw_ready_during_rsp: got %b want 0", req_ready_o); end
    step();
    rsp_valid_i = 0; rsp_ready_i = 0;
    @(negedge clk_i);
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL sw_ready_after: got %b want 1", req_ready_o); end
    n_cmp++; if (mst_valid_o !== 2'b10) begin n_err++; $display("FAIL sw_valid_after: got %b want 10", mst_valid_o); end
    step();
    req_valid_i = 0;
    rsp_valid_i = 2'b10; rsp_ready_i = 1;
    @(negedge clk_i);
    n_cmp++; if (rsp_ready_o !== 2'b10) begin n_err++; $display("FAIL sw_rsp_ready: got %b want 10", rsp_ready_o); end
    step();
    rsp_valid_i = 0; rsp_ready_i = 0;
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL sw_busy_end: got %b want 0", busy_o); end
    step();
  endtask

  task automatic test_saturation();
    req_idx_i = 0;
    for (int i = 0; i < MT; i++) begin
      req_valid_i = 1;
      @(negedge clk_i);
      n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL sat_fill_ready[%0d]: got %b want 1", i, req_ready_o); end
      step();
    end
    @(negedge clk_i);
    n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL sat_5th_ready: got %b want 0", req_ready_o); end
    n_cmp++; if (mst_valid_o !== 2'b00) begin n_err++; $display("FAIL sat_5th_valid: got %b want 00", mst_valid_o); end
    n_cmp++; if (dut.cnt_q !== 3'd4) begin n_err++; $display("FAIL sat_cnt_full: got %0d want 4", dut.cnt_q); end
    step();
    rsp_valid_i = 2'b01; rsp_ready_i = 1;
    @(negedge clk_i);
    n_cmp++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL sat_rsp_cycle_ready: got %b want 0", req_ready_o); end
    step();
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd3) begin n_err++; $display("FAIL sat_cnt_after_rsp: got %0d want 3", dut.cnt_q); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL sat_ready_below_max: got %b want 1", req_ready_o); end
    step();
    rsp_valid_i = 0; rsp_ready_i = 0;
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd3) begin n_err++; $display("FAIL sat_cnt_both: got %0d want 3", dut.cnt_q); end
    step();
    req_valid_i = 0;
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd4) begin n_err++; $display("FAIL sat_cnt_refill: got %0d want 4", dut.cnt_q); end
    step();
    rsp_valid_i = 2'b01; rsp_ready_i = 1;
    for (int i = 0; i < MT; i++) step();
    rsp_valid_i = 0; rsp_ready_i = 0;
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_err++; $display("FAIL sat_cnt_drained: got %0d want 0", dut.cnt_q); end
    step();
  endtask

  task automatic test_dec_error();
    req_valid_i = 1; req_idx_i = 1; req_dec_error_i = 1;
    @(negedge clk_i);
    n_cmp++; if (mst_valid_o !== 2'b00) begin n_err++; $display("FAIL err_mst_valid: got %b want 00", mst_valid_o); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL err_req_ready: got %b want 1", req_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL err_rsp_early: got %b want 0", rsp_valid_o); end
    step();
    req_valid_i = 0; req_dec_error_i = 0; rsp_ready_i = 1;
    rsp_data_i[1] = 32'hDEAD_BEEF;
    @(negedge clk_i);
    n_cmp++; if (rsp_valid_o !== 1'b1) begin n_err++; $display("FAIL err_rsp_valid: got %b want 1", rsp_valid_o); end
    n_cmp++; if (rsp_err_o !== 1'b1) begin n_err++; $display("FAIL err_rsp_err: got %b want 1", rsp_err_o); end
    n_cmp++; if (rsp_data_o !== '0) begin n_err++; $display("FAIL err_rsp_data: got %h want 0", rsp_data_o); end
    n_cmp++; if (rsp_ready_o !== 2'b00) begin n_err++; $display("FAIL err_port_ready: got %b want 00", rsp_ready_o); end
    step();
    rsp_ready_i = 0;
    @(negedge clk_i);
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL err_rsp_done: got %b want 0", rsp_valid_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL err_busy_done: got %b want 0", busy_o); end
    step();
  endtask

  task automatic test_reset_mid();
    req_valid_i = 1; req_idx_i = 1;
    step(); step();
    req_valid_i = 0;
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd2) begin n_err++; $display("FAIL rmid_cnt_before: got %0d want 2", dut.cnt_q); end
    step();
    rst_i = 1; rsp_valid_i = 2'b10;
    step();
    rst_i = 0;
    @(negedge clk_i);
    n_cmp++; if (dut.cnt_q !== 3'd0) begin n_err++; $display("FAIL rmid_cnt: got %0d want 0", dut.cnt_q); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rmid_req_ready: got %b want 1", req_ready_o); end
    n_cmp++; if (rsp_valid_o !== 1'b0) begin n_err++; $display("FAIL rmid_rsp_valid: got %b want 0", rsp_valid_o); end
    step();
    rsp_valid_i = 0;
  endtask

  typedef struct {
    bit            err;
    int            port;
    logic [RW-1:0] data;
  } txn_t;

  // Reference: a FIFO of outstanding transactions in issue order, plus one
  // response FIFO per downstream port model.
  task automatic test_random();
    txn_t          outq[$];
    logic [RW-1:0] pq0[$];
    logic [RW-1:0] pq1[$];
    txn_t          f, t;
    bit            pend = 0, r_err = 0, stall, e_ready, e_rv;
    int            r_idx = 0, n, lock, tgt;
    logic [PW-1:0] r_pay = '0;
    logic [NP-1:0] e_mv, e_rr;
    idle_inputs();
    rst_i = 1; step(); rst_i = 0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      if (!pend && ($urandom % 4 != 0)) begin
        pend = 1; r_idx = int'($urandom % 2); r_err = ($urandom % 8 == 0); r_pay = $urandom;
      end
      req_valid_i = pend; req_idx_i = r_idx[0]; req_dec_error_i = r_err; req_payload_i = r_pay;
      mst_ready_i = 2'($urandom); rsp_ready_i = 1'($urandom);
      rsp_valid_i[0] = (pq0.size() > 0) && ($urandom % 2 == 0);
      rsp_valid_i[1] = (pq1.size() > 0) && ($urandom % 2 == 0);
      rsp_data_i[0] = (pq0.size() > 0) ? pq0[0] : RW'($urandom);
      rsp_data_i[1] = (pq1.size() > 0) ? pq1[0] : RW'($urandom);
      @(negedge clk_i);
      n = outq.size();
      lock = (n > 0) ? (outq[n-1].err ? NP : outq[n-1].port) : -1;
      tgt = r_err ? NP : r_idx;
      stall = (n > 0) && ((tgt != lock) || (n == MT));
      e_ready = !stall && (r_err || mst_ready_i[r_idx]);
      e_mv = (pend && !stall && !r_err) ? NP'(1 << r_idx) : '0;
      e_rv = 0; e_rr = '0;
      if (n > 0) begin
        f = outq[0];
        e_rv = f.err ? 1'b1 : rsp_valid_i[f.port];
        e_rr = (f.err || !rsp_ready_i) ? '0 : NP'(1 << f.port);
      end
      n_cmp++; if (req_ready_o !== e_ready) begin n_err++; $display("FAIL rnd_req_ready @%0d: got %b want %b", cyc, req_ready_o, e_ready); end
      n_cmp++; if (mst_valid_o !== e_mv) begin n_err++; $display("FAIL rnd_mst_valid @%0d: got %b want %b", cyc, mst_valid_o, e_mv); end
      n_cmp++; if (rsp_valid_o !== e_rv) begin n_err++; $display("FAIL rnd_rsp_valid @%0d: got %b want %b", cyc, rsp_valid_o, e_rv); end
      n_cmp++; if (busy_o !== (n > 0)) begin n_err++; $display("FAIL rnd_busy @%0d: got %b want %b", cyc, busy_o, n > 0); end
      if (e_mv != '0) begin
        n_cmp++; if (mst_payload_o !== r_pay) begin n_err++; $display("FAIL rnd_payload @%0d: got %h want %h", cyc, mst_payload_o, r_pay); end
      end
      if (n > 0) begin
        n_cmp++; if (rsp_ready_o !== e_rr) begin n_err++; $display("FAIL rnd_rsp_ready @%0d: got %b want %b", cyc, rsp_ready_o, e_rr); end
      end
      if (e_rv) begin
        n_cmp++; if (rsp_err_o !== f.err) begin n_err++; $display("FAIL rnd_rsp_err @%0d: got %b want %b", cyc, rsp_err_o, f.err); end
        n_cmp++; if (rsp_data_o !== (f.err ? '0 : f.data)) begin n_err++; $display("FAIL rnd_rsp_data @%0d: got %h want %h", cyc, rsp_data_o, f.err ? '0 : f.data); end
      end
      if (e_rv && rsp_ready_i) begin
        void'(outq.pop_front());
        if (!f.err) begin
          if (f.port == 0) void'(pq0.pop_front()); else void'(pq1.pop_front());
        end
      end
      if (pend && e_ready) begin
        t.err = r_err; t.port = r_idx; t.data = $urandom;
        outq.push_back(t);
        if (!r_err) begin
          if (r_idx == 0) pq0.push_back(t.data); else pq1.push_back(t.data);
        end
        pend = 0;
      end
      step();
    end
    idle_inputs();
  endtask

`ifdef ADDR_ROUTE_DEMUX_SPILL_EN
  task automatic test_spill();
    req_valid_i = 1; req_idx_i = 0;
    @(negedge clk_i);
    n_cmp++; if (mst_valid_o !== 2'b00) begin n_err++; $display("FAIL spill_latency0: got %b want 00", mst_valid_o); end
    step();
    req_valid_i = 0;
    @(negedge clk_i);
    n_cmp++; if (mst_valid_o !== 2'b01) begin n_err++; $display("FAIL spill_latency1: got %b want 01", mst_valid_o); end
    step();
    rsp_valid_i = 2'b01; rsp_ready_i = 1;
    step();
    rsp_valid_i = 0; rsp_ready_i = 0;
    @(negedge clk_i);
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL spill_drain: got %b want 0", busy_o); end
    step();
  endtask
`endif

  initial begin
    idle_inputs();
    rst_i = 1;
    test_reset();
`ifdef ADDR_ROUTE_DEMUX_SPILL_EN
    test_spill();
`else
    test_back_to_back();
    test_switch();
    test_saturation();
    test_dec_error();
    test_reset_mid();
    test_random();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
